// File: rtl/pht_update_queue_pkg.sv
// pht_update_queue_pkg: PHT geometry, update-queue entry types and bank-conflict helper.
package pht_update_queue_pkg;
  localparam int PHT_ENTRY_NUM_BIT_WIDTH = 10;
  localparam int PHT_ENTRY_WIDTH = 2;
  localparam int PHT_BANK_NUM_BIT_WIDTH = 2;
  localparam int PHT_QUEUE_SIZE = 32;
  localparam int PHT_QUEUE_SIZE_BIT_WIDTH = $clog2(PHT_QUEUE_SIZE);
  localparam int FETCH_WIDTH = 2;
  typedef logic [PHT_ENTRY_NUM_BIT_WIDTH-1:0] PHT_IndexPath;
  typedef logic [PHT_ENTRY_WIDTH-1:0] PHT_EntryPath;
  typedef logic [PHT_QUEUE_SIZE_BIT_WIDTH:0] PhtQueueCountPath;
  localparam PHT_EntryPath PHT_ENTRY_MAX = '1;
  localparam PHT_IndexPath PHT_BANK_MASK = PHT_IndexPath'((1 << PHT_BANK_NUM_BIT_WIDTH) - 1);
  typedef struct packed {
    PHT_IndexPath index;
    PHT_EntryPath value;
  } PhtUpdateQueueEntry;
  // Banks are selected by the low index bits.
  function automatic logic IsBankConflict(PHT_IndexPath a, PHT_IndexPath b);
    return ((a ^ b) & PHT_BANK_MASK) == '0;
  endfunction
endpackage

// File: rtl/pht_update_queue_counter.sv
// pht_counter_update: 2-bit saturating counter step with no-change detect.
module pht_counter_update
  import pht_update_queue_pkg::*;
(
  input  PHT_EntryPath prev,
  input  logic         taken,
  output PHT_EntryPath next,
  output logic         changed
);
  assign next = taken ? ((prev == PHT_ENTRY_MAX) ? prev : prev + PHT_EntryPath'(1))
                      : ((prev == '0) ? prev : prev - PHT_EntryPath'(1));
  assign changed = next != prev;
endmodule

// File: rtl/pht_update_queue.sv
// pht_update_queue: buffers PHT counter updates and drains them around fetch bank conflicts.
module pht_update_queue
  import pht_update_queue_pkg::*;
#(
  parameter int QUEUE_SIZE = PHT_QUEUE_SIZE,
  parameter int READ_PORT_NUM = FETCH_WIDTH
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             brValid,
  input  logic                                             brIsCondBr,
  input  logic                                             brIsApBr,
  input  logic                                             brExecTaken,
  input  logic [PHT_ENTRY_NUM_BIT_WIDTH-1:0]               brPhtIndex,
  input  logic [PHT_ENTRY_WIDTH-1:0]                       brPhtPrevValue,
  input  logic [READ_PORT_NUM-1:0]                         fetchReadValid,
  input  logic [READ_PORT_NUM-1:0][PHT_ENTRY_NUM_BIT_WIDTH-1:0] fetchReadIndex,
  output logic                                             phtWE,
  output logic [PHT_ENTRY_NUM_BIT_WIDTH-1:0]               phtWA,
  output logic [PHT_ENTRY_WIDTH-1:0]                       phtWV,
  output logic                                             phtForceWrite,
  output logic [$clog2(QUEUE_SIZE):0]                      queueCount,
  output logic                                             queueFull,
  output logic                                             queueEmpty
);
  localparam int PW = $clog2(QUEUE_SIZE);
  PhtUpdateQueueEntry queue [QUEUE_SIZE];
  PhtUpdateQueueEntry headEntry;
  logic [PW-1:0] headPtr, tailPtr;
  logic [PW:0] count;
  PHT_EntryPath newValue;
  logic changed, push, conflict;
  pht_counter_update counterUpdate (
    .prev(brPhtPrevValue),
    .taken(brExecTaken),
    .next(newValue),
    .changed(changed)
  );
  assign push = brValid & brIsCondBr & ~brIsApBr & changed;
  assign headEntry = queue[headPtr];
  always_comb begin
    conflict = 1'b0;
    for (int p = 0; p < READ_PORT_NUM; p++)
      conflict = conflict | (fetchReadValid[p] & IsBankConflict(headEntry.index, fetchReadIndex[p]));
  end
  assign queueEmpty = count == '0;
  assign queueFull = count == (PW+1)'(QUEUE_SIZE);
  assign queueCount = count;
  // A full queue drains even under conflict, so a push is never refused.
  assign phtWE = ~queueEmpty & (~conflict | queueFull);
  assign phtForceWrite = phtWE & conflict;
  assign phtWA = headEntry.index;
  assign phtWV = headEntry.value;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headPtr <= '0;
      tailPtr <= '0;
      count <= '0;
    end else begin
      headPtr <= phtWE ? headPtr + PW'(1) : headPtr;
      tailPtr <= push ? tailPtr + PW'(1) : tailPtr;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, phtWE};
    end
  end
  always_ff @(posedge clk) begin
    if (push) queue[tailPtr] <= '{index: brPhtIndex, value: newValue};
  end
endmodule

// File: tb/tb_pht_update_queue.sv
// tb_pht_update_queue: random and directed stimulus checked against a queue-based reference model.
module tb_pht_update_queue;
  logic clk = 0, rst = 1;
  logic brValid = 0, brIsCondBr = 0, brIsApBr = 0, brExecTaken = 0;
  logic [9:0] brPhtIndex = 0;
  logic [1:0] brPhtPrevValue = 0;
  logic [1:0] fetchReadValid = 0;
  logic [1:0][9:0] fetchReadIndex = '0;
  logic phtWE, phtForceWrite, queueFull, queueEmpty;
  logic [9:0] phtWA;
  logic [1:0] phtWV;
  logic [5:0] queueCount;
  int vectors = 0, miscompares = 0;
  typedef struct { int idx; int val; } ent_t;
  ent_t mq[$];

  pht_update_queue dut (
    .clk(clk), .rst(rst), .brValid(brValid), .brIsCondBr(brIsCondBr), .brIsApBr(brIsApBr),
    .brExecTaken(brExecTaken), .brPhtIndex(brPhtIndex), .brPhtPrevValue(brPhtPrevValue),
    .fetchReadValid(fetchReadValid), .fetchReadIndex(fetchReadIndex), .phtWE(phtWE), .phtWA(phtWA),
    .phtWV(phtWV), .phtForceWrite(phtForceWrite), .queueCount(queueCount), .queueFull(queueFull),
    .queueEmpty(queueEmpty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setIn(input bit v, c, a, t, input int idx, prev, input bit [1:0] fv, input int f0, f1);
    brValid = v; brIsCondBr = c; brIsApBr = a; brExecTaken = t;
    brPhtIndex = 10'(idx); brPhtPrevValue = 2'(prev);
    fetchReadValid = fv; fetchReadIndex[0] = 10'(f0); fetchReadIndex[1] = 10'(f1);
  endtask

  task automatic idle();
    setIn(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: updated once per cycle from the spec's rules.
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      chk("rst_we", int'(phtWE), 0);
      chk("rst_count", int'(queueCount), 0);
      chk("rst_empty", int'(queueEmpty), 1);
    end else begin
      automatic bit conf = 0;
      automatic bit expWE;
      automatic int nv;
      automatic bit doPush;
      if (mq.size() > 0)
        for (int p = 0; p < 2; p++)
          if (fetchReadValid[p] && (mq[0].idx % 4) == (int'(fetchReadIndex[p]) % 4)) conf = 1;
      expWE = mq.size() > 0 && (!conf || mq.size() == 32);
      chk("we", int'(phtWE), int'(expWE));
      chk("force", int'(phtForceWrite), int'(expWE && conf));
      chk("count", int'(queueCount), mq.size());
      chk("full", int'(queueFull), int'(mq.size() == 32));
      chk("empty", int'(queueEmpty), int'(mq.size() == 0));
      if (mq.size() > 0) begin
        chk("wa", int'(phtWA), mq[0].idx);
        chk("wv", int'(phtWV), mq[0].val);
      end
      nv = brExecTaken ? (brPhtPrevValue == 3 ? 3 : int'(brPhtPrevValue) + 1)
                       : (brPhtPrevValue == 0 ? 0 : int'(brPhtPrevValue) - 1);
      doPush = brValid && brIsCondBr && !brIsApBr && nv != int'(brPhtPrevValue);
      if (expWE) void'(mq.pop_front());
      if (doPush) mq.push_back('{int'(brPhtIndex), nv});
    end
  end

  initial begin
    int guard;
    idle();
    repeat (2) step();
    rst = 0;
    step();
    chk("idle_empty", int'(queueEmpty), 1);
    chk("idle_count", int'(queueCount), 0);
    chk("idle_we", int'(phtWE), 0);
    // single push then immediate drain
    setIn(1, 1, 0, 1, 'h12, 1, 2'b00, 0, 0);
    step();
    idle();
    #1;
    chk("lit_we", int'(phtWE), 1);
    chk("lit_wa", int'(phtWA), 'h12);
    chk("lit_wv", int'(phtWV), 2);
    chk("lit_force", int'(phtForceWrite), 0);
    step();
    chk("lit_empty_t2", int'(queueEmpty), 1);
    // saturated and approximate updates are dropped
    setIn(1, 1, 0, 1, 'h40, 3, 2'b00, 0, 0); step();
    chk("drop_sat_hi", int'(queueCount), 0);
    setIn(1, 1, 0, 0, 'h41, 0, 2'b00, 0, 0); step();
    chk("drop_sat_lo", int'(queueCount), 0);
    setIn(1, 1, 1, 1, 'h42, 1, 2'b00, 0, 0); step();
    chk("drop_apbr", int'(queueCount), 0);
    chk("drop_we", int'(phtWE), 0);
    // bank conflict holds head
    setIn(1, 1, 0, 1, 'h20, 1, 2'b00, 0, 0); step();
    setIn(0, 0, 0, 0, 0, 0, 2'b01, 'h30, 0);
    #1;
    chk("conf_we", int'(phtWE), 0);
    step();
    chk("conf_held", int'(queueCount), 1);
    idle();
    #1;
    chk("conf_rel_we", int'(phtWE), 1);
    chk("conf_rel_wa", int'(phtWA), 'h20);
    step();
    // fill under continuous conflict
    for (int i = 0; i < 32; i++) begin
      setIn(1, 1, 0, 1, i * 4, 1, 2'b01, 'h30, 0);
      step();
    end
    setIn(1, 1, 0, 0, 'h99, 2, 2'b01, 'h30, 0);
    #1;
    chk("full_flag", int'(queueFull), 1);
    chk("full_we", int'(phtWE), 1);
    chk("full_force", int'(phtForceWrite), 1);
    step();
    chk("full_count", int'(queueCount), 32);
    idle();
    guard = 0;
    while (!queueEmpty && guard < 40) begin step(); guard++; end
    chk("drain_done", int'(queueEmpty), 1);
    // same index ordering
    setIn(1, 1, 0, 1, 'h5, 1, 2'b00, 0, 0); step();
    setIn(1, 1, 0, 1, 'h5, 2, 2'b00, 0, 0);
    #1;
    chk("ord_wv0", int'(phtWV), 2);
    step();
    idle();
    #1;
    chk("ord_wa1", int'(phtWA), 'h5);
    chk("ord_wv1", int'(phtWV), 3);
    step();
    // async reset with pending entries
    for (int i = 0; i < 5; i++) begin
      setIn(1, 1, 0, 0, 'h100 + i * 4, 2, 2'b01, 'h30, 0);
      step();
    end
    idle();
    fetchReadValid = 2'b01; fetchReadIndex[0] = 10'h30;
    #1;
    chk("pre_rst_count", int'(queueCount), 5);
    rst = 1;
    #1;
    chk("async_rst_count", int'(queueCount), 0);
    chk("async_rst_we", int'(phtWE), 0);
    step();
    rst = 0;
    idle();
    step();
    // randomized traffic including wrap-around
    for (int i = 0; i < 600; i++) begin
      setIn($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0,
            1'($urandom), $urandom_range(0, 1023), $urandom_range(0, 3),
            {$urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4},
            $urandom_range(0, 1023), $urandom_range(0, 1023));
      step();
    end
    idle();
    guard = 0;
    while (!queueEmpty && guard < 40) begin step(); guard++; end
    chk("final_empty", int'(queueEmpty), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pht_update_queue.md
Name: pht_update_queue

Overview:
Sits directly downstream of integer-execute branch resolution and upstream of the PHT RAM write port. It consumes resolved conditional branch results (BranchResult fields), computes the 2-bit saturating-counter update, and buffers it in a FIFO. It drains one write per cycle into the PHT whenever that write does not bank-conflict with the fetch-stage PHT reads of the same cycle. This keeps the shared-bank PHT single-write while never stalling fetch, except on a forced drain when the FIFO is full.

Parameters:
QUEUE_SIZE, PHT_QUEUE_SIZE (32), FIFO depth; must be a power of two, at least 2.
READ_PORT_NUM, FETCH_WIDTH, number of fetch-stage PHT read ports checked for conflict.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
brValid  in  1  resolved branch result valid (BranchResult.valid)
brIsCondBr  in  1  BranchResult.isCondBr
brIsApBr  in  1  BranchResult.isApBr
brExecTaken  in  1  BranchResult.execTaken
brPhtIndex  in  PHT_ENTRY_NUM_BIT_WIDTH  BranchResult.phtIndex
brPhtPrevValue  in  PHT_ENTRY_WIDTH  BranchResult.phtPrevValue
fetchReadValid  in  READ_PORT_NUM  per-port PHT read enable this cycle
fetchReadIndex  in  READ_PORT_NUM x PHT_ENTRY_NUM_BIT_WIDTH  per-port PHT read index
phtWE  out  1  PHT write enable
phtWA  out  PHT_ENTRY_NUM_BIT_WIDTH  PHT write index
phtWV  out  PHT_ENTRY_WIDTH  PHT write value
phtForceWrite  out  1  write issued despite a bank conflict (FIFO full)
queueCount  out  PHT_QUEUE_SIZE_BIT_WIDTH+1  occupied entries
queueFull  out  1  queueCount == QUEUE_SIZE
queueEmpty  out  1  queueCount == 0

Behaviour:
- Reset (async, rst=1): head=tail=0, count=0. phtWE=0, phtForceWrite=0, queueEmpty=1, queueFull=0, queueCount=0. Reset mid-operation discards all pending entries immediately.
- Training filter: a push candidate exists when brValid & brIsCondBr & !brIsApBr. Approximate branches never train the PHT.
- Counter update: taken gives newV = (prev==PHT_ENTRY_MAX) ? prev : prev+1. Not-taken gives newV = (prev==0) ? 0 : prev-1.
- Push occurs only if the candidate exists and newV != prev; saturated no-change updates are dropped.
- Entry stored: {index=brPhtIndex, value=newV}. Push is registered; the earliest write for an entry pushed in cycle t is cycle t+1. There is no same-cycle bypass.
- Drain (combinational on registered head and fetch inputs):
  - conflict = OR over ports p of fetchReadValid[p] & IsBankConflict(head.index, fetchReadIndex[p]).
  - phtWE = !empty & (!conflict | full).
  - phtForceWrite = phtWE & conflict.
  - phtWA/phtWV = head fields. When phtWE=0 they are don't-care but held at head.
  - Head advances at the clock edge when phtWE=1.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Full: a forced drain happens every cycle while full, so a push in a full cycle is always accepted (pop frees a slot the same edge). No update is ever lost.
- Wrap-around: pointers are PHT_QUEUE_SIZE_BIT_WIDTH bits and wrap modulo QUEUE_SIZE. The separate count register distinguishes full from empty.
- Ordering: strict FIFO. Two updates to the same index are written in push order; there is no coalescing.
- Empty with push: the entry is visible at head next cycle and can be written that cycle if there is no conflict.

Decomposition:
- FetchUnitTypes gains PhtUpdateQueueEntry {PHT_IndexPath index; PHT_EntryPath value} and PhtQueueCountPath (PHT_QUEUE_SIZE_BIT_WIDTH+1 bits).
- Reuse PHT_QUEUE_SIZE, PHT_ENTRY_MAX and IsBankConflict from the package.
- One natural sub-module: pht_counter_update, the combinational saturating inc/dec plus no-change detect, reused by gshare training.
- FIFO storage is a flat register array inside pht_update_queue.

Test Plan:
- Reset then idle -> queueEmpty=1, queueCount=0, phtWE=0. Assert rst mid-stream with 5 entries queued -> next cycle count=0 and phtWE=0.
- Push idx=0x12, prev=1, taken, no fetch reads -> at t+1: phtWE=1, phtWA=0x12, phtWV=2, phtForceWrite=0; at t+2: queueEmpty=1.
- Push prev=3 taken, prev=0 not-taken, and isApBr=1 prev=1 taken -> nothing enqueued, phtWE never 1.
- Head idx=0x20 with fetchReadValid[0]=1 and fetchReadIndex[0]=0x30 (same low bank bits) -> phtWE=0, entry held. Remove the read -> phtWE=1, phtWA=0x20.
- Hold a conflicting read continuously, push 32 updates -> queueFull=1 after 32. The next cycle gives phtWE=1 and phtForceWrite=1. A push that same cycle is accepted and count stays 32.
- Push idx 0x5 taken prev=1, then idx 0x5 taken prev=2 -> writes in order: 0x5<-2, then 0x5<-3. Run 40 push/pop cycles to exercise pointer wrap -> order preserved.
